// File: rtl/data_memory_ls_if.sv
// Load/store request bus for the byte-addressed MEM-stage data memory.
interface data_memory_ls_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [31:0]           read_data;
  logic                  rd_valid;
  logic                  addr_err;

  // Pipeline side issues requests
  modport master (
    output address, write_data, mem_read, mem_write, size, sign_ext,
    input  read_data, rd_valid, addr_err
  );

  // Memory side serves requests
  modport slave (
    input  address, write_data, mem_read, mem_write, size, sign_ext,
    output read_data, rd_valid, addr_err
  );
endinterface

// File: rtl/data_memory_ls.sv
// Byte-addressed data memory with MIPS load/store sizes, selectable lane
// order, registered load result and optional same-cycle write-to-read bypass.
module data_memory_ls #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned BIG_ENDIAN  = 1,
  parameter int unsigned BYPASS      = 1
) (
  input logic             clk,
  input logic             rst_n,
  data_memory_ls_if.slave bus
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]  word_idx_c;
  logic [1:0]        off_c;
  logic [MEM_AW-1:0] mem_idx_c;
  logic              range_err_c;
  logic              align_err_c;
  logic              fault_c;
  logic              wr_en_c;
  logic [2:0]        nbytes_c;
  logic [1:0]        shift_c;
  logic [4:0]        shamt_c;
  logic [31:0]       size_mask_c;
  logic [31:0]       lane_mask_c;
  logic [31:0]       wr_word_c;
  logic [31:0]       old_word_c;
  logic [31:0]       merged_word_c;
  logic [31:0]       rd_word_c;
  logic [31:0]       lane_data_c;
  logic [31:0]       load_val_c;

  logic [31:0]       read_data_q, read_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  // Decode address/size into fault flags and the lane shift of the access
  always_comb begin
    word_idx_c  = bus.address[ADDR_WIDTH-1:2];
    off_c       = bus.address[1:0];
    mem_idx_c   = word_idx_c[MEM_AW-1:0];
    range_err_c = 32'(word_idx_c) >= DEPTH_WORDS;
    nbytes_c    = 3'd1;
    size_mask_c = 32'h0;
    align_err_c = 1'b1;
    case (bus.size)
      2'b00: begin
        nbytes_c    = 3'd1;
        size_mask_c = 32'h0000_00FF;
        align_err_c = 1'b0;
      end
      2'b01: begin
        nbytes_c    = 3'd2;
        size_mask_c = 32'h0000_FFFF;
        align_err_c = off_c[0];
      end
      2'b10: begin
        nbytes_c    = 3'd4;
        size_mask_c = 32'hFFFF_FFFF;
        align_err_c = (off_c != 2'b00);
      end
      default: begin
        nbytes_c    = 3'd1;
        size_mask_c = 32'h0;
        align_err_c = 1'b1;
      end
    endcase
    // Big-endian puts the lowest-addressed byte in the most significant lane
    shift_c = (BIG_ENDIAN != 0) ? 2'(3'd4 - nbytes_c - {1'b0, off_c}) : off_c;
    shamt_c = {shift_c, 3'b000};
    fault_c = range_err_c | align_err_c;
    wr_en_c = rst_n & bus.mem_write & ~fault_c;
  end

  // Merge store lanes into the addressed word and extract the load lanes
  always_comb begin
    lane_mask_c   = size_mask_c << shamt_c;
    wr_word_c     = (bus.write_data & size_mask_c) << shamt_c;
    old_word_c    = mem_q[mem_idx_c];
    merged_word_c = (old_word_c & ~lane_mask_c) | wr_word_c;
    rd_word_c     = ((BYPASS != 0) && wr_en_c) ? merged_word_c : old_word_c;
    lane_data_c   = rd_word_c >> shamt_c;
    case (bus.size)
      2'b00:   load_val_c = bus.sign_ext ? {{24{lane_data_c[7]}}, lane_data_c[7:0]}
                                         : {24'h0, lane_data_c[7:0]};
      2'b01:   load_val_c = bus.sign_ext ? {{16{lane_data_c[15]}}, lane_data_c[15:0]}
                                         : {16'h0, lane_data_c[15:0]};
      default: load_val_c = lane_data_c;
    endcase
  end

  // Storage array; no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[mem_idx_c] <= merged_word_c;
    end
  end

  // Next-state for the registered load result and status pulses
  always_comb begin
    read_data_d = read_data_q;
    rd_valid_d  = bus.mem_read;
    addr_err_d  = (bus.mem_read | bus.mem_write) & fault_c;
    if (bus.mem_read) begin
      read_data_d = fault_c ? 32'h0 : load_val_c;
    end
  end

  // Output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= 32'h0;
      rd_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Bench for data_memory_ls: three configurations driven with identical requests.
//   dut 0: 8-bit address, big-endian, bypass on
//   dut 1: 8-bit address, little-endian, bypass off
//   dut 2: 9-bit address, big-endian, bypass on (reaches out-of-range words)
module tb_data_memory_ls;

  logic        clk;
  logic        rst_n;
  logic [8:0]  d_addr;
  logic [31:0] d_wd;
  logic        d_rd;
  logic        d_wr;
  logic [1:0]  d_size;
  logic        d_se;

  int checks;
  int failures;

  // Byte-addressed reference memory, one per configuration
  logic [7:0]  mm [3][256];
  logic        exp_v [3];
  logic        exp_e [3];
  logic [31:0] exp_d [3];
  logic        obs_v [3];
  logic        obs_e [3];
  logic [31:0] obs_d [3];

  data_memory_ls_if #(.ADDR_WIDTH(8)) if_a ();
  data_memory_ls_if #(.ADDR_WIDTH(8)) if_b ();
  data_memory_ls_if #(.ADDR_WIDTH(9)) if_c ();

  assign if_a.address = d_addr[7:0];
  assign if_b.address = d_addr[7:0];
  assign if_c.address = d_addr;
  assign if_a.write_data = d_wd;
  assign if_b.write_data = d_wd;
  assign if_c.write_data = d_wd;
  assign if_a.mem_read = d_rd;
  assign if_b.mem_read = d_rd;
  assign if_c.mem_read = d_rd;
  assign if_a.mem_write = d_wr;
  assign if_b.mem_write = d_wr;
  assign if_c.mem_write = d_wr;
  assign if_a.size = d_size;
  assign if_b.size = d_size;
  assign if_c.size = d_size;
  assign if_a.sign_ext = d_se;
  assign if_b.sign_ext = d_se;
  assign if_c.sign_ext = d_se;

  data_memory_ls #(.DEPTH_WORDS(64), .ADDR_WIDTH(8), .BIG_ENDIAN(1), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  data_memory_ls #(.DEPTH_WORDS(64), .ADDR_WIDTH(8), .BIG_ENDIAN(0), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  data_memory_ls #(.DEPTH_WORDS(64), .ADDR_WIDTH(9), .BIG_ENDIAN(1), .BYPASS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cfg_be(input int k);
    return k != 1;
  endfunction

  function automatic bit cfg_byp(input int k);
    return k != 1;
  endfunction

  function automatic logic [33:0] pk(input logic v, input logic e, input logic [31:0] d);
    return {v, e, d};
  endfunction

  function automatic logic [33:0] got(input int k);
    return {obs_v[k], obs_e[k], obs_d[k]};
  endfunction

  // Store n bytes starting at byte address a, most significant first when big-endian
  function automatic void mstore(input int k, input int unsigned a, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      mm[k][a + i] = cfg_be(k) ? 8'(d_wd >> (8 * (n - 1 - i))) : 8'(d_wd >> (8 * i));
    end
  endfunction

  // Gather n bytes starting at a, right-justify and extend
  function automatic logic [31:0] mload(input int k, input int unsigned a, input int unsigned n);
    int unsigned v;
    v = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (cfg_be(k)) v = (v << 8) | 32'(mm[k][a + i]);
      else           v = v | (32'(mm[k][a + i]) << (8 * i));
    end
    if (n < 4 && d_se && (((v >> (8 * n - 1)) & 1) != 0)) begin
      v = v | ~((32'd1 << (8 * n)) - 1);
    end
    return 32'(v);
  endfunction

  // Predict next-cycle outputs for the request currently on the inputs
  function automatic void model(input int k);
    int unsigned a;
    int unsigned n;
    bit flt;
    a = (k == 2) ? 32'(d_addr) : 32'(d_addr[7:0]);
    case (d_size)
      2'd0:    n = 1;
      2'd1:    n = 2;
      2'd2:    n = 4;
      default: n = 0;
    endcase
    flt = (n == 0);
    if (!flt) flt = (a % n != 0) || (a / 4 >= 64);
    if (!rst_n) begin
      exp_v[k] = 1'b0;
      exp_e[k] = 1'b0;
      exp_d[k] = 32'h0;
      return;
    end
    exp_v[k] = d_rd;
    exp_e[k] = (d_rd || d_wr) && flt;
    if (d_wr && !flt && cfg_byp(k)) mstore(k, a, n);
    if (d_rd) exp_d[k] = flt ? 32'h0 : mload(k, a, n);
    if (d_wr && !flt && !cfg_byp(k)) mstore(k, a, n);
  endfunction

  task automatic capture();
    obs_v[0] = if_a.rd_valid; obs_e[0] = if_a.addr_err; obs_d[0] = if_a.read_data;
    obs_v[1] = if_b.rd_valid; obs_e[1] = if_b.addr_err; obs_d[1] = if_b.read_data;
    obs_v[2] = if_c.rd_valid; obs_e[2] = if_c.addr_err; obs_d[2] = if_c.read_data;
  endtask

  // One request cycle: drive, update model, clock, sample 1 time unit after the edge
  task automatic step(input logic [8:0] a, input logic [31:0] wd, input logic r,
                      input logic w, input logic [1:0] sz, input logic se);
    d_addr = a; d_wd = wd; d_rd = r; d_wr = w; d_size = sz; d_se = se;
    for (int k = 0; k < 3; k++) model(k);
    @(posedge clk);
    #1;
    capture();
    d_rd = 1'b0; d_wr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    capture();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b0, 1'b0, 32'h0)) begin
        failures++;
        $display("FAIL reset_async dut%0d got=%h want=%h", k, got(k), pk(1'b0, 1'b0, 32'h0));
      end
    end
    // A load presented during reset must be ignored
    step(9'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b0, 1'b0, 32'h0)) begin
        failures++;
        $display("FAIL reset_ignore dut%0d got=%h want=%h", k, got(k), pk(1'b0, 1'b0, 32'h0));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic init_mem();
    for (int w = 0; w < 64; w++) step(9'(w * 4), 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
  endtask

  task automatic test_word_store_load();
    step(9'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b0, 1'b0, 32'h0)) begin
        failures++;
        $display("FAIL sw_no_pulse dut%0d got=%h want=%h", k, got(k), pk(1'b0, 1'b0, 32'h0));
      end
    end
    step(9'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b0, 32'hDEADBEEF)) begin
        failures++;
        $display("FAIL lw_word dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b0, 32'hDEADBEEF));
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [33:0] want;
    step(9'h20, 32'h11223344, 1'b0, 1'b1, 2'b10, 1'b0);
    step(9'h22, 32'hABCDEFF0, 1'b0, 1'b1, 2'b00, 1'b0);
    step(9'h20, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      want = (k == 1) ? pk(1'b1, 1'b0, 32'h11F03344) : pk(1'b1, 1'b0, 32'h1122F044);
      checks++;
      if (got(k) !== want) begin
        failures++;
        $display("FAIL sb_merge dut%0d got=%h want=%h", k, got(k), want);
      end
    end
    step(9'h22, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b0, 32'hFFFFFFF0)) begin
        failures++;
        $display("FAIL lb_signed dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b0, 32'hFFFFFFF0));
      end
    end
    step(9'h22, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b0, 32'h000000F0)) begin
        failures++;
        $display("FAIL lbu dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b0, 32'h000000F0));
      end
    end
    step(9'h21, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      want = (k == 1) ? pk(1'b1, 1'b0, 32'h00000033) : pk(1'b1, 1'b0, 32'h00000022);
      checks++;
      if (got(k) !== want) begin
        failures++;
        $display("FAIL lbu_lane1 dut%0d got=%h want=%h", k, got(k), want);
      end
    end
  endtask

  task automatic test_halfword();
    logic [33:0] want;
    step(9'h30, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
    step(9'h32, 32'h12348001, 1'b0, 1'b1, 2'b01, 1'b0);
    step(9'h32, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b0, 32'hFFFF8001)) begin
        failures++;
        $display("FAIL lh_signed dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b0, 32'hFFFF8001));
      end
    end
    step(9'h32, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b0, 32'h00008001)) begin
        failures++;
        $display("FAIL lhu dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b0, 32'h00008001));
      end
    end
    step(9'h30, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      want = (k == 1) ? pk(1'b1, 1'b0, 32'h80010000) : pk(1'b1, 1'b0, 32'h00008001);
      checks++;
      if (got(k) !== want) begin
        failures++;
        $display("FAIL sh_lane dut%0d got=%h want=%h", k, got(k), want);
      end
    end
    step(9'h31, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b1, 32'h0)) begin
        failures++;
        $display("FAIL lh_misaligned dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b1, 32'h0));
      end
    end
  endtask

  task automatic test_faults();
    logic [33:0] want;
    step(9'h12, 32'h12345678, 1'b0, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({obs_v[k], obs_e[k]} !== 2'b01) begin
        failures++;
        $display("FAIL sw_misaligned dut%0d got v/e=%b want v/e=01", k, {obs_v[k], obs_e[k]});
      end
    end
    step(9'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({obs_v[k], obs_e[k]} !== 2'b00) begin
        failures++;
        $display("FAIL err_one_cycle dut%0d got v/e=%b want v/e=00", k, {obs_v[k], obs_e[k]});
      end
    end
    step(9'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b0, 32'hDEADBEEF)) begin
        failures++;
        $display("FAIL lw_after_fault dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b0, 32'hDEADBEEF));
      end
    end
    // 0x100 is out of range for the 9-bit instance; the 8-bit ones see address 0
    step(9'h100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      want = (k == 2) ? pk(1'b1, 1'b1, 32'h0) : pk(1'b1, 1'b0, 32'h0);
      checks++;
      if (got(k) !== want) begin
        failures++;
        $display("FAIL lw_range dut%0d got=%h want=%h", k, got(k), want);
      end
    end
    step(9'h20, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b1, 32'h0)) begin
        failures++;
        $display("FAIL load_size11 dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b1, 32'h0));
      end
    end
    step(9'h20, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b11, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({obs_v[k], obs_e[k]} !== 2'b01) begin
        failures++;
        $display("FAIL store_size11 dut%0d got v/e=%b want v/e=01", k, {obs_v[k], obs_e[k]});
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [33:0] want;
    step(9'h40, 32'hAAAAAAAA, 1'b0, 1'b1, 2'b10, 1'b0);
    step(9'h40, 32'h55555555, 1'b1, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      want = (k == 1) ? pk(1'b1, 1'b0, 32'hAAAAAAAA) : pk(1'b1, 1'b0, 32'h55555555);
      checks++;
      if (got(k) !== want) begin
        failures++;
        $display("FAIL rw_bypass dut%0d got=%h want=%h", k, got(k), want);
      end
    end
    step(9'h40, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b0, 32'h55555555)) begin
        failures++;
        $display("FAIL rw_after dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b0, 32'h55555555));
      end
    end
    step(9'h42, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b1, 1'b1, 32'h0)) begin
        failures++;
        $display("FAIL rw_fault dut%0d got=%h want=%h", k, got(k), pk(1'b1, 1'b1, 32'h0));
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] want_d [4];
    logic [8:0]  adr [4];
    step(9'h20, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    capture();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== pk(1'b0, 1'b0, 32'h0)) begin
        failures++;
        $display("FAIL reset_mid dut%0d got=%h want=%h", k, got(k), pk(1'b0, 1'b0, 32'h0));
      end
    end
    // Store issued while reset is held must not land
    step(9'h20, 32'hCAFEBABE, 1'b0, 1'b1, 2'b10, 1'b0);
    rst_n = 1'b1;
    adr[0] = 9'h10; adr[1] = 9'h20; adr[2] = 9'h30; adr[3] = 9'h40;
    for (int k = 0; k < 3; k++) begin
      want_d[0] = 32'hDEADBEEF;
      want_d[1] = (k == 1) ? 32'h11F03344 : 32'h1122F044;
      want_d[2] = (k == 1) ? 32'h80010000 : 32'h00008001;
      want_d[3] = 32'h55555555;
    end
    for (int i = 0; i < 4; i++) begin
      step(adr[i], 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      for (int k = 0; k < 3; k++) begin
        want_d[1] = (k == 1) ? 32'h11F03344 : 32'h1122F044;
        want_d[2] = (k == 1) ? 32'h80010000 : 32'h00008001;
        checks++;
        if (got(k) !== pk(1'b1, 1'b0, want_d[i])) begin
          failures++;
          $display("FAIL back_to_back%0d dut%0d got=%h want=%h", i, k, got(k), pk(1'b1, 1'b0, want_d[i]));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0]  a;
    logic [1:0]  sz;
    logic [33:0] want;
    for (int n = 0; n < 500; n++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(256, 511)) : 9'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
           1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
        want = {exp_v[k], exp_e[k], exp_d[k]};
        checks++;
        if (got(k) !== want) begin
          failures++;
          $display("FAIL random%0d dut%0d addr=%h size=%0d got=%h want=%h", n, k, a, sz, got(k), want);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    d_addr   = 9'h0;
    d_wd     = 32'h0;
    d_rd     = 1'b0;
    d_wr     = 1'b0;
    d_size   = 2'b00;
    d_se     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_v[k] = 1'b0;
      exp_e[k] = 1'b0;
      exp_d[k] = 32'h0;
    end
    test_reset();
    init_mem();
    test_word_store_load();
    test_byte_lanes();
    test_halfword();
    test_faults();
    test_simultaneous();
    test_back_to_back_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
